// File: rtl/vector_sequencer.sv
// Steps a 3-bit stimulus vector 0..7 with a programmable hold per vector, then pulses done.
// Defining SEQ_CAPTURE_EN adds the results port and per-vector capture of {x_in,y_in}.
module vector_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  hold_cycles,
    input  logic        x_in,
    input  logic        y_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic [2:0]  vec_idx,
    output logic        busy,
    output logic        done
`ifdef SEQ_CAPTURE_EN
    ,
    output logic [15:0] results
`endif
);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | sweeping vectors 0..7, each held for the latched N cycles
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  n_reg;
    logic [7:0]  hold_cnt;
    logic [7:0]  n_eff;
    logic        start_ok;
    logic        hold_expired;
    logic        last_vec;

    assign n_eff        = (hold_cycles == 8'd0) ? 8'd1 : hold_cycles;
    assign start_ok     = (state == S_IDLE) && start;
    assign hold_expired = (state == S_RUN) && (hold_cnt == 8'd0);
    assign last_vec     = (vec_idx == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // abort outranks a simultaneous hold expiry
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (hold_expired && last_vec) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
        a    = vec_idx[2];
        b    = vec_idx[1];
        c    = vec_idx[0];
    end

    // Hold timer counts down from N-1; zero marks the final cycle of the current vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg    <= 8'd1;
            hold_cnt <= 8'd0;
            vec_idx  <= 3'd0;
        end else if (start_ok) begin
            n_reg    <= n_eff;
            hold_cnt <= n_eff - 8'd1;
            vec_idx  <= 3'd0;
        end else if (state == S_RUN) begin
            if (abort || (hold_expired && last_vec)) begin
                hold_cnt <= 8'd0;
                vec_idx  <= 3'd0;
            end else if (hold_expired) begin
                hold_cnt <= n_reg - 8'd1;
                vec_idx  <= vec_idx + 3'd1;
            end else begin
                hold_cnt <= hold_cnt - 8'd1;
            end
        end
    end

`ifdef SEQ_CAPTURE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            results <= 16'h0000;
        end else if (start_ok) begin
            results <= 16'h0000;
        end else if (hold_expired && !abort) begin
            results[{vec_idx, 1'b0} +: 2] <= {x_in, y_in};
        end
    end
`else
    logic unused_xy;
    assign unused_xy = x_in ^ y_in;
`endif

endmodule

// File: tb/tb_vector_sequencer.sv
// Self-checking bench for vector_sequencer; expected timing derived from sweep cycle arithmetic.
// Capture checks are active when SEQ_CAPTURE_EN is defined.
module tb_vector_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  hold_cycles;
    logic        x_in;
    logic        y_in;
    logic        a;
    logic        b;
    logic        c;
    logic [2:0]  vec_idx;
    logic        busy;
    logic        done;
`ifdef SEQ_CAPTURE_EN
    logic [15:0] results;
`endif

    int checks = 0;
    int errors = 0;

    vector_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .hold_cycles (hold_cycles),
        .x_in        (x_in),
        .y_in        (y_in),
        .a           (a),
        .b           (b),
        .c           (c),
        .vec_idx     (vec_idx),
        .busy        (busy),
        .done        (done)
`ifdef SEQ_CAPTURE_EN
        ,
        .results     (results)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // downstream circuit under test: x = parity, y = a&b | c
    assign x_in = a ^ b ^ c;
    assign y_in = (a & b) | c;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] expected_results();
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            r[2*i+1] = ^i[2:0];
            r[2*i]   = (i[2] & i[1]) | i[0];
        end
        return r;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
        chk({tag, "_done"}, {15'd0, done}, 16'd0);
        chk({tag, "_vec"}, {13'd0, vec_idx}, 16'd0);
        chk({tag, "_abc"}, {13'd0, a, b, c}, 16'd0);
    endtask

    // One sweep: abort_k<0 means no abort; hold input changes to new_hold mid-sweep.
    task automatic sweep(input int hin, input int abort_k, input int new_hold,
                         input bit keep_start, input bit noise);
        int  n;
        int  v;
        bit  aborted;
        hold_cycles = hin[7:0];
        start = 1'b1;
        tick();
        if (!keep_start) start = 1'b0;
        n = (hin == 0) ? 1 : hin;
        aborted = 1'b0;
`ifdef SEQ_CAPTURE_EN
        chk("results_cleared", results, 16'h0000);
`endif
        for (int k = 0; k < 8 * n && !aborted; k++) begin
            v = k / n;
            chk("run_busy", {15'd0, busy}, 16'd1);
            chk("run_done", {15'd0, done}, 16'd0);
            chk("run_vec", {13'd0, vec_idx}, v[15:0]);
            chk("run_abc", {13'd0, a, b, c}, v[15:0]);
            if (k == n + n / 2) hold_cycles = new_hold[7:0];
            if (!keep_start) start = (noise && k < 8 * n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (k == abort_k) begin
                abort = 1'b1;
                start = 1'b0;
                tick();
                abort = 1'b0;
                check_idle("abort");
                for (int j = 0; j < 3; j++) begin
                    tick();
                    chk("abort_no_done", {15'd0, done}, 16'd0);
                end
                aborted = 1'b1;
            end else begin
                tick();
            end
        end
        if (!aborted) begin
            chk("done_pulse", {15'd0, done}, 16'd1);
            chk("done_busy", {15'd0, busy}, 16'd0);
            chk("done_vec", {13'd0, vec_idx}, 16'd0);
            chk("done_abc", {13'd0, a, b, c}, 16'd0);
`ifdef SEQ_CAPTURE_EN
            chk("results_done", results, expected_results());
`endif
            tick();
            check_idle("post_done");
`ifdef SEQ_CAPTURE_EN
            chk("results_stable", results, expected_results());
`endif
        end
    endtask

    initial begin
        int hin;
        int ak;
        int nh;
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        hold_cycles = 8'd1;
        #12;
        check_idle("reset");
`ifdef SEQ_CAPTURE_EN
        chk("reset_results", results, 16'h0000);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // abort while idle has no effect
        abort = 1'b1;
        tick();
        tick();
        abort = 1'b0;
        check_idle("idle_abort");

        sweep(1, -1, 1, 1'b0, 1'b0);
        sweep(0, -1, 0, 1'b0, 1'b0);
        sweep(10, -1, 3, 1'b0, 1'b0);
        sweep(3, 4 * 3 + 1, 3, 1'b0, 1'b0);
        sweep(2, -1, 2, 1'b0, 1'b0);
        sweep(2, 5, 2, 1'b0, 1'b0);

        // asynchronous reset during vector 5
        hold_cycles = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5 * 2 + 1; k++) tick();
        chk("pre_reset_vec", {13'd0, vec_idx}, 16'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
`ifdef SEQ_CAPTURE_EN
        chk("async_reset_results", results, 16'h0000);
`endif
        @(posedge clk);
        #1;
        check_idle("reset_held");
        rst_n = 1'b1;
        sweep(1, -1, 1, 1'b0, 1'b0);

        // start held high through DONE retriggers exactly once
        sweep(2, -1, 2, 1'b1, 1'b0);
        sweep(3, -1, 3, 1'b0, 1'b0);
        tick();
        check_idle("single_retrigger");

        for (int r = 0; r < 8; r++) begin
            hin = $urandom_range(0, 5);
            n = (hin == 0) ? 1 : hin;
            nh = $urandom_range(0, 12);
            ak = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8 * n - 1) : -1;
            sweep(hin, ak, nh, 1'b0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
